// File: rtl/grid_pr_slot_multi_if.sv
// Handshake/bus bundle for the multi-input grid PR slot shell.
// Groups operand channels, OU-facing signals, result stream and LS gate.
interface grid_pr_slot_multi_if #(
    parameter int XLEN       = 32,
    parameter int NUM_INPUTS = 3,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                       flush;
    logic [NUM_INPUTS*XLEN-1:0] data_in;
    logic [NUM_INPUTS-1:0]      data_valid_in;
    logic [NUM_INPUTS-1:0]      data_ready_in;
    logic [NUM_INPUTS*CW-1:0]   fifo_count;
    logic [NUM_INPUTS-1:0]      overflow_err;
    logic [NUM_INPUTS*XLEN-1:0] ou_data;
    logic [NUM_INPUTS-1:0]      ou_data_valid;
    logic [NUM_INPUTS-1:0]      ou_ack;
    logic [NUM_INPUTS-1:0]      ou_uses;
    logic [XLEN-1:0]            ou_result;
    logic                       ou_result_valid;
    logic                       ou_result_ready;
    logic [XLEN-1:0]            data_out;
    logic                       data_valid_out;
    logic                       data_ready_out;
    logic                       ou_new_request;
    logic                       ou_load;
    logic                       ou_request_stall;
    logic                       new_request;
    logic                       lsq_full;
    logic                       load_complete;

    modport slave (
        input  flush, data_in, data_valid_in, ou_ack, ou_uses,
        input  ou_result, ou_result_valid, data_ready_out,
        input  ou_new_request, ou_load, lsq_full, load_complete,
        output data_ready_in, fifo_count, overflow_err,
        output ou_data, ou_data_valid, ou_result_ready,
        output data_out, data_valid_out,
        output ou_request_stall, new_request
    );

    modport master (
        output flush, data_in, data_valid_in, ou_ack, ou_uses,
        output ou_result, ou_result_valid, data_ready_out,
        output ou_new_request, ou_load, lsq_full, load_complete,
        input  data_ready_in, fifo_count, overflow_err,
        input  ou_data, ou_data_valid, ou_result_ready,
        input  data_out, data_valid_out,
        input  ou_request_stall, new_request
    );
endinterface

// File: rtl/grid_pr_slot_multi.sv
// Grid PR slot shell: per-channel operand FIFOs, registered result stage,
// LS request gate with outstanding-load limit.
// Ports: clk, rst (sync, active-high), bus (grid_pr_slot_multi_if.slave).
module grid_pr_slot_multi #(
    parameter int XLEN            = 32,
    parameter int NUM_INPUTS      = 3,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                  clk,
    input logic                  rst,
    grid_pr_slot_multi_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
        logic [XLEN-1:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0]   r_wp;
        logic [AW-1:0]   r_rp;
        logic [CW-1:0]   r_cnt;
        logic            r_ovf;
        logic            w_full;
        logic            w_offer;
        logic            w_push;
        logic            w_pop;

        // Ready comes from the registered count only: no pop credit.
        assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
        assign w_offer = bus.data_valid_in[g] & bus.ou_uses[g];
        assign w_push  = w_offer & ~w_full & ~bus.flush;
        assign w_pop   = bus.ou_ack[g] & (r_cnt != '0) & ~bus.flush;

        always_ff @(posedge clk) begin
            if (rst || bus.flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push) r_wp <= r_wp + 1'b1;
                if (w_pop)  r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
                if (w_offer && w_full) r_ovf <= 1'b1;
            end
        end

        // Storage needs no reset; pointers define validity.
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wp] <= bus.data_in[g*XLEN +: XLEN];
        end

        assign bus.data_ready_in[g]            = ~w_full;
        assign bus.overflow_err[g]             = r_ovf;
        assign bus.fifo_count[g*CW +: CW]      = r_cnt;
        assign bus.ou_data_valid[g]            = (r_cnt != '0);
        assign bus.ou_data[g*XLEN +: XLEN]     = r_mem[r_rp];
    end

    logic [XLEN-1:0] r_dout;
    logic            r_vout;
    logic            w_rrdy;

    assign w_rrdy              = ~r_vout | bus.data_ready_out;
    assign bus.ou_result_ready = w_rrdy;
    assign bus.data_out        = r_dout;
    assign bus.data_valid_out  = r_vout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_vout <= 1'b0;
        end else if (bus.flush) begin
            r_vout <= 1'b0;
        end else if (bus.ou_result_valid && w_rrdy) begin
            r_dout <= bus.ou_result;
            r_vout <= 1'b1;
        end else if (bus.data_ready_out) begin
            r_vout <= 1'b0;
        end
    end

    logic [OW-1:0] r_out;
    logic          w_block;
    logic          w_newreq;
    logic          w_inc;
    logic          w_dec;

    assign w_block  = bus.lsq_full | bus.flush
                    | (bus.ou_load & (r_out == OW'(MAX_OUTSTANDING)));
    assign w_newreq = bus.ou_new_request & ~w_block;
    assign bus.new_request      = w_newreq;
    assign bus.ou_request_stall = bus.ou_new_request & w_block;

    // A completion with nothing outstanding is a protocol error; ignore it.
    assign w_inc = w_newreq & bus.ou_load;
    assign w_dec = bus.load_complete & (r_out != '0);

    // Loads in flight still return across a flush, so only rst clears this.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_inc && !w_dec) begin
            r_out <= r_out + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_out <= r_out - 1'b1;
        end
    end
endmodule

// File: tb/tb_grid_pr_slot_multi.sv
// Self-checking bench for grid_pr_slot_multi: directed steps then
// randomized traffic, all checked against a queue-based reference model.
module tb_grid_pr_slot_multi;
    localparam int XL = 32;
    localparam int NI = 3;
    localparam int D  = 8;
    localparam int MO = 4;
    localparam int CW = $clog2(D) + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    grid_pr_slot_multi_if #(.XLEN(XL), .NUM_INPUTS(NI), .FIFO_DEPTH(D)) bus ();

    grid_pr_slot_multi #(
        .XLEN(XL), .NUM_INPUTS(NI), .FIFO_DEPTH(D), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [XL-1:0] q [NI][$];
    logic [NI-1:0] m_ovf;
    logic          m_vo;
    logic [XL-1:0] m_dout;
    int            m_out;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush = 0;
        bus.data_in = '0;
        bus.data_valid_in = '0;
        bus.ou_ack = '0;
        bus.ou_uses = '0;
        bus.ou_result = '0;
        bus.ou_result_valid = 0;
        bus.data_ready_out = 1;
        bus.ou_new_request = 0;
        bus.ou_load = 0;
        bus.lsq_full = 0;
        bus.load_complete = 0;
    endtask

    task automatic check_state();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("cnt%0d", i),
                bus.fifo_count[i*CW +: CW], q[i].size());
            chk($sformatf("vld%0d", i), bus.ou_data_valid[i], q[i].size() > 0);
            chk($sformatf("rdy%0d", i), bus.data_ready_in[i], q[i].size() != D);
            if (q[i].size() > 0)
                chk($sformatf("head%0d", i), bus.ou_data[i*XL +: XL], q[i][0]);
        end
        chk("ovf", bus.overflow_err, m_ovf);
        chk("vout", bus.data_valid_out, m_vo);
        chk("dout", bus.data_out, m_dout);
    endtask

    // Called at a negedge with inputs already applied; returns at next negedge.
    task automatic cycle();
        logic rr, blk, nr, lc, inc, full, offer;
        #1;
        rr  = !m_vo || bus.data_ready_out;
        blk = bus.lsq_full || bus.flush || (bus.ou_load && m_out == MO);
        nr  = bus.ou_new_request && !blk;
        if (!rst) begin
            chk("rrdy", bus.ou_result_ready, rr);
            chk("newreq", bus.new_request, nr);
            chk("stall", bus.ou_request_stall, bus.ou_new_request && blk);
        end
        if (rst) begin
            for (int i = 0; i < NI; i++) q[i].delete();
            m_ovf = '0; m_vo = 0; m_dout = '0; m_out = 0;
        end else begin
            lc  = bus.load_complete && m_out > 0;
            inc = nr && bus.ou_load;
            if (inc && !lc) m_out++;
            else if (lc && !inc) m_out--;
            if (bus.flush) begin
                for (int i = 0; i < NI; i++) q[i].delete();
                m_ovf = '0; m_vo = 0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    full  = q[i].size() == D;
                    offer = bus.data_valid_in[i] && bus.ou_uses[i];
                    if (bus.ou_ack[i] && q[i].size() > 0) void'(q[i].pop_front());
                    if (offer && !full) q[i].push_back(bus.data_in[i*XL +: XL]);
                    if (offer && full) m_ovf[i] = 1;
                end
                if (bus.ou_result_valid && rr) begin
                    m_vo = 1; m_dout = bus.ou_result;
                end else if (bus.data_ready_out) m_vo = 0;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_ovf = '0; m_vo = 0; m_dout = '0; m_out = 0;
        idle();
        rst = 1;
        @(negedge clk);
        cycle(); cycle();
        rst = 0;
        chk("rst_cnt", bus.fifo_count, 0);
        chk("rst_rdy", bus.data_ready_in, 3'b111);

        // ch0 push three, then drain
        bus.ou_uses = 3'b001;
        bus.data_valid_in = 3'b001;
        bus.data_in[31:0] = 32'h11; cycle();
        chk("first_head", bus.ou_data[31:0], 32'h11);
        bus.data_in[31:0] = 32'h22; cycle();
        bus.data_in[31:0] = 32'h33; cycle();
        chk("cnt3", bus.fifo_count[CW-1:0], 3);
        bus.data_valid_in = '0;
        bus.ou_ack = 3'b001;
        cycle(); chk("head22", bus.ou_data[31:0], 32'h22);
        cycle(); chk("head33", bus.ou_data[31:0], 32'h33);
        cycle(); chk("empty0", bus.ou_data_valid[0], 1'b0);
        bus.ou_ack = '0;

        // ch1 fill, overflow, drain, flush
        bus.ou_uses = 3'b010;
        bus.data_valid_in = 3'b010;
        for (int k = 0; k < D; k++) begin
            bus.data_in[XL +: XL] = 32'h100 + k; cycle();
        end
        chk("full_rdy", bus.data_ready_in[1], 1'b0);
        bus.data_in[XL +: XL] = 32'h1FF; cycle();
        chk("ovf1", bus.overflow_err[1], 1'b1);
        bus.data_valid_in = '0;
        bus.ou_ack = 3'b010;
        for (int k = 0; k < D; k++) begin
            chk("drain", bus.ou_data[XL +: XL], 32'h100 + k);
            cycle();
        end
        chk("no9th", bus.ou_data_valid[1], 1'b0);
        bus.ou_ack = '0;
        bus.data_valid_in = 3'b010;
        bus.data_in[XL +: XL] = 32'h77; cycle();
        bus.data_valid_in = '0;
        bus.flush = 1; cycle(); bus.flush = 0;
        chk("fl_cnt", bus.fifo_count[CW +: CW], 0);
        chk("fl_ovf", bus.overflow_err[1], 1'b0);

        // unused channel, then push+pop streaming on ch0
        bus.ou_uses = 3'b001;
        bus.data_valid_in = 3'b100;
        bus.data_in[2*XL +: XL] = 32'h55;
        cycle(); cycle();
        chk("unused_cnt", bus.fifo_count[2*CW +: CW], 0);
        chk("unused_ovf", bus.overflow_err[2], 1'b0);
        bus.data_valid_in = 3'b001;
        bus.data_in[31:0] = 32'h200; cycle();
        bus.ou_ack = 3'b001;
        for (int k = 0; k < 20; k++) begin
            chk("stream", bus.ou_data[31:0], 32'h200 + k);
            bus.data_in[31:0] = 32'h201 + k; cycle();
            chk("stream_cnt", bus.fifo_count[CW-1:0], 1);
        end
        idle();
        cycle();

        // result stage backpressure
        bus.data_ready_out = 0;
        bus.ou_result_valid = 1;
        bus.ou_result = 32'hA; cycle();
        bus.ou_result = 32'hB; cycle();
        chk("bp_rrdy", bus.ou_result_ready, 1'b0);
        chk("bp_hold", bus.data_out, 32'hA);
        bus.data_ready_out = 1; cycle();
        chk("rel_B", bus.data_out, 32'hB);
        bus.ou_result_valid = 0; cycle();
        chk("rel_vo", bus.data_valid_out, 1'b0);

        // outstanding load limit
        bus.ou_new_request = 1; bus.ou_load = 1;
        repeat (MO) cycle();
        #1;
        chk("ld5_stall", bus.ou_request_stall, 1'b1);
        chk("ld5_nr", bus.new_request, 1'b0);
        cycle();
        bus.ou_new_request = 0; bus.load_complete = 1; cycle();
        bus.ou_new_request = 1;
        #1 chk("lc_and_ld", bus.new_request, 1'b1);
        cycle();
        bus.load_complete = 0; cycle();
        #1 chk("at_max", bus.ou_request_stall, 1'b1);
        bus.ou_load = 0; bus.lsq_full = 1;
        #1 chk("lsq_store", bus.ou_request_stall, 1'b1);
        cycle();
        bus.lsq_full = 0; bus.ou_new_request = 0;

        // flush keeps outstanding count
        bus.load_complete = 1; cycle(); cycle();
        bus.load_complete = 0;
        bus.flush = 1; bus.ou_new_request = 1; bus.ou_load = 1;
        #1 chk("fl_block", bus.new_request, 1'b0);
        cycle();
        bus.flush = 0;
        cycle(); cycle();
        #1 chk("kept2", bus.ou_request_stall, 1'b1);
        bus.ou_new_request = 0; bus.load_complete = 1;
        repeat (MO) cycle();
        bus.load_complete = 0; bus.ou_new_request = 1;
        repeat (MO) cycle();
        #1 chk("refill", bus.ou_request_stall, 1'b1);
        idle();
        bus.load_complete = 1;
        repeat (MO) cycle();
        idle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(99) == 0);
            bus.flush = ($urandom_range(49) == 0);
            bus.data_valid_in = 3'($urandom_range(7));
            bus.ou_uses = 3'($urandom_range(7));
            bus.ou_ack = ($urandom_range(2) == 0) ? 3'b000 : 3'($urandom_range(7));
            for (int i = 0; i < NI; i++) bus.data_in[i*XL +: XL] = $urandom;
            bus.ou_result_valid = 1'($urandom_range(1));
            bus.ou_result = $urandom;
            bus.data_ready_out = 1'($urandom_range(1));
            bus.ou_new_request = 1'($urandom_range(1));
            bus.ou_load = 1'($urandom_range(1));
            bus.lsq_full = ($urandom_range(3) == 0);
            bus.load_complete = (m_out > 0) && ($urandom_range(2) == 0);
            cycle();
        end
        rst = 0;
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
